// File: rtl/calyx_mem_pkg.sv
// Shared definitions for the sequential Calyx memory family (d1..d4).
// Holds the pipeline-stage record and the parameter legality check.
package calyx_mem_pkg;

    localparam int MEM_MAX_LATENCY = 4;

    typedef struct packed {
        logic valid;
        logic is_write;
        logic oob;
    } mem_stage_t;

    function automatic bit mem_params_ok(
        input int width,
        input int size,
        input int idx_size,
        input int latency
    );
        longint cap;
        if (width < 1 || size < 1 || idx_size < 1 || idx_size > 31) begin
            return 1'b0;
        end
        cap = longint'(1) << idx_size;
        return (cap >= longint'(size)) && (latency >= 1) && (latency <= MEM_MAX_LATENCY);
    endfunction

endpackage

// File: rtl/std_delay_pipe.sv
// Fixed-depth valid+payload shift register with no backpressure.
// Only the valid bits are reset; payload registers are free-running.
module std_delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            valid_d;
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;

    always_comb begin
        valid_d    = '0;
        data_d     = '0;
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/std_seq_mem_d1.sv
// 1-D memory with a synchronous read sampled at acceptance and a fixed-latency
// completion pipeline reporting done/oob; read data lands in a holding register.
module std_seq_mem_d1 #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4,
    parameter int LATENCY  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] addr0,
    input  logic                content_en,
    input  logic                write_en,
    input  logic [WIDTH-1:0]    write_data,
    output logic [WIDTH-1:0]    read_data,
    output logic                done,
    output logic                oob
);

    import calyx_mem_pkg::*;

    if (!mem_params_ok(WIDTH, SIZE, IDX_SIZE, LATENCY)) begin : g_param_check
        $fatal(1, "std_seq_mem_d1: illegal WIDTH/SIZE/IDX_SIZE/LATENCY combination");
    end

    localparam int                PAY_W  = WIDTH + 2;
    localparam int                AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_SIZE:0] SIZE_W = SIZE[IDX_SIZE:0];

    logic [WIDTH-1:0] mem_q [SIZE];

    logic             in_range;
    logic             mem_we;
    logic [AW-1:0]    mem_idx;
    logic [WIDTH-1:0] rd_word;
    mem_stage_t       s0_stage;
    logic [PAY_W-1:0] s0_payload;

    logic             pre_valid;
    logic [PAY_W-1:0] pre_payload;

    logic             done_d;
    logic             done_q;
    logic             oob_d;
    logic             oob_q;
    logic [WIDTH-1:0] read_data_d;
    logic [WIDTH-1:0] read_data_q;

    // In-range implies the upper address bits are zero, so the narrow index is exact.
    always_comb begin
        in_range          = ({1'b0, addr0} < SIZE_W);
        mem_idx           = addr0[AW-1:0];
        mem_we            = reset & content_en & write_en & in_range;
        rd_word           = in_range ? mem_q[mem_idx] : '0;
        s0_stage.valid    = content_en;
        s0_stage.is_write = write_en;
        s0_stage.oob      = ~in_range;
        s0_payload        = {s0_stage.is_write, s0_stage.oob, rd_word};
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= write_data;
        end
    end

    // The last stage lives here as done/oob/read_data; the sub-pipe supplies the rest.
    if (LATENCY > 1) begin : g_pipe
        std_delay_pipe #(
            .WIDTH (PAY_W),
            .DEPTH (LATENCY - 1)
        ) u_pipe (
            .clk       (clk),
            .rst_n     (reset),
            .in_valid  (s0_stage.valid),
            .in_data   (s0_payload),
            .out_valid (pre_valid),
            .out_data  (pre_payload)
        );
    end else begin : g_direct
        assign pre_valid   = s0_stage.valid;
        assign pre_payload = s0_payload;
    end

    always_comb begin
        done_d      = pre_valid;
        oob_d       = pre_valid & pre_payload[PAY_W-2];
        read_data_d = read_data_q;
        if (pre_valid && !pre_payload[PAY_W-1]) begin
            read_data_d = pre_payload[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= 1'b0;
            oob_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            done_q      <= done_d;
            oob_q       <= oob_d;
            read_data_q <= read_data_d;
        end
    end

    assign done      = done_q;
    assign oob       = oob_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Directed bench: four instances (LATENCY 1..4, SIZE=10) share one stimulus stream,
// each checked against its own completion timing.
module tb_std_seq_mem_d1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr0;
    logic        content_en;
    logic        write_en;
    logic [31:0] write_data;

    logic [31:0] rd [1:4];
    logic [4:1]  dn;
    logic [4:1]  ob;

    int checks   = 0;
    int failures = 0;

    // request table for the current scenario, plus hand-written expectations
    logic        r_we   [32];
    logic [3:0]  r_addr [32];
    logic [31:0] r_wd   [32];
    logic [31:0] r_exp  [32];
    logic        r_oob  [32];
    int          n_req;
    logic [31:0] exp_hold [1:4];

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        std_seq_mem_d1 #(
            .WIDTH    (32),
            .SIZE     (10),
            .IDX_SIZE (4),
            .LATENCY  (g)
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n),
            .addr0      (addr0),
            .content_en (content_en),
            .write_en   (write_en),
            .write_data (write_data),
            .read_data  (rd[g]),
            .done       (dn[g]),
            .oob        (ob[g])
        );
    end

    task automatic add_req(input logic we, input logic [3:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_oob);
        r_we[n_req]   = we;
        r_addr[n_req] = a;
        r_wd[n_req]   = wd;
        r_exp[n_req]  = exp_rd;
        r_oob[n_req]  = exp_oob;
        n_req++;
    endtask

    task automatic drive(input int m);
        if (m < n_req) begin
            content_en = 1'b1;
            write_en   = r_we[m];
            addr0      = r_addr[m];
            write_data = r_wd[m];
        end else begin
            content_en = 1'b0;
            write_en   = 1'b0;
            addr0      = 4'd0;
            write_data = 32'd0;
        end
    endtask

    task automatic test_reset;
        content_en = 1'b1;
        write_en   = 1'b0;
        addr0      = 4'd3;
        write_data = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                checks++;
                if (dn[l] !== 1'b0 || ob[l] !== 1'b0 || rd[l] !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_hold L=%0d c=%0d done=%b oob=%b rd=%h, want 0/0/0",
                             l, c, dn[l], ob[l], rd[l]);
                end
            end
        end
        n_req = 0;
        drive(0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                checks++;
                if (dn[l] !== 1'b0 || ob[l] !== 1'b0 || rd[l] !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_idle L=%0d c=%0d done=%b oob=%b rd=%h, want 0/0/0",
                             l, c, dn[l], ob[l], rd[l]);
                end
            end
        end
        for (int l = 1; l <= 4; l++) exp_hold[l] = 32'd0;
    endtask

    task automatic test_write_read;
        n_req = 0;
        add_req(1'b1, 4'd5, 32'hDEADBEEF, 32'd0, 1'b0);
        add_req(1'b0, 4'd5, 32'd0, 32'hDEADBEEF, 1'b0);
        for (int m = 0; m <= n_req + 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                logic e_oob;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                e_oob  = 1'b0;
                if (e_done) begin
                    e_oob = r_oob[r];
                    if (!r_we[r]) exp_hold[l] = r_exp[r];
                end
                checks++;
                if (dn[l] !== e_done || ob[l] !== e_oob || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL write_read L=%0d m=%0d done=%b want %b oob=%b want %b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], e_oob, rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
    endtask

    task automatic test_back_to_back;
        n_req = 0;
        for (int i = 0; i < 8; i++) add_req(1'b1, 4'(i), 32'(i * 3), 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) add_req(1'b0, 4'(i), 32'd0, 32'(i * 3), 1'b0);
        for (int m = 0; m <= n_req + 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                logic e_oob;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                e_oob  = 1'b0;
                if (e_done) begin
                    e_oob = r_oob[r];
                    if (!r_we[r]) exp_hold[l] = r_exp[r];
                end
                checks++;
                if (dn[l] !== e_done || ob[l] !== e_oob || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL back_to_back L=%0d m=%0d done=%b want %b oob=%b want %b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], e_oob, rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
    endtask

    task automatic test_oob;
        n_req = 0;
        add_req(1'b1, 4'd8,  32'h88, 32'd0, 1'b0);
        add_req(1'b1, 4'd9,  32'h99, 32'd0, 1'b0);
        add_req(1'b1, 4'd12, 32'h55, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) add_req(1'b0, 4'(i), 32'd0, 32'(i * 3), 1'b0);
        add_req(1'b0, 4'd8,  32'd0, 32'h88, 1'b0);
        add_req(1'b0, 4'd9,  32'd0, 32'h99, 1'b0);
        add_req(1'b0, 4'd12, 32'd0, 32'd0, 1'b1);
        add_req(1'b0, 4'd15, 32'd0, 32'd0, 1'b1);
        for (int m = 0; m <= n_req + 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                logic e_oob;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                e_oob  = 1'b0;
                if (e_done) begin
                    e_oob = r_oob[r];
                    if (!r_we[r]) exp_hold[l] = r_exp[r];
                end
                checks++;
                if (dn[l] !== e_done || ob[l] !== e_oob || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL out_of_range L=%0d m=%0d done=%b want %b oob=%b want %b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], e_oob, rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
    endtask

    task automatic test_reset_midflight;
        n_req = 0;
        add_req(1'b0, 4'd7, 32'd0, 32'd21, 1'b0);
        add_req(1'b0, 4'd1, 32'd0, 32'd3,  1'b0);
        add_req(1'b0, 4'd2, 32'd0, 32'd6,  1'b0);
        for (int m = 0; m <= 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                if (e_done) exp_hold[l] = r_exp[r];
                checks++;
                if (dn[l] !== e_done || ob[l] !== 1'b0 || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL pre_reset L=%0d m=%0d done=%b want %b oob=%b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int l = 1; l <= 4; l++) begin
            exp_hold[l] = 32'd0;
            checks++;
            if (dn[l] !== 1'b0 || ob[l] !== 1'b0 || rd[l] !== 32'd0) begin
                failures++;
                $display("FAIL reset_async L=%0d done=%b oob=%b rd=%h, want 0/0/0",
                         l, dn[l], ob[l], rd[l]);
            end
        end
        // a write presented during reset must not reach the array
        content_en = 1'b1;
        write_en   = 1'b1;
        addr0      = 4'd1;
        write_data = 32'h0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                checks++;
                if (dn[l] !== 1'b0 || ob[l] !== 1'b0 || rd[l] !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_flush L=%0d c=%0d done=%b oob=%b rd=%h, want 0/0/0",
                             l, c, dn[l], ob[l], rd[l]);
                end
            end
        end
        n_req = 0;
        drive(0);
        rst_n = 1'b1;
        add_req(1'b0, 4'd1, 32'd0, 32'd3, 1'b0);
        for (int m = 0; m <= n_req + 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                if (e_done) exp_hold[l] = r_exp[r];
                checks++;
                if (dn[l] !== e_done || ob[l] !== 1'b0 || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL post_reset_read L=%0d m=%0d done=%b want %b oob=%b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
    endtask

    task automatic test_sweep;
        n_req = 0;
        add_req(1'b1, 4'd0, 32'h0000A5A5, 32'd0, 1'b0);
        add_req(1'b0, 4'd0, 32'd0, 32'h0000A5A5, 1'b0);
        for (int m = 0; m <= n_req + 4; m++) begin
            @(negedge clk);
            for (int l = 1; l <= 4; l++) begin
                int   r;
                logic e_done;
                logic e_oob;
                r      = m - l;
                e_done = (r >= 0) && (r < n_req);
                e_oob  = 1'b0;
                if (e_done) begin
                    e_oob = r_oob[r];
                    if (!r_we[r]) exp_hold[l] = r_exp[r];
                end
                checks++;
                if (dn[l] !== e_done || ob[l] !== e_oob || rd[l] !== exp_hold[l]) begin
                    failures++;
                    $display("FAIL latency_sweep L=%0d m=%0d done=%b want %b oob=%b want %b rd=%h want %h",
                             l, m, dn[l], e_done, ob[l], e_oob, rd[l], exp_hold[l]);
                end
            end
            drive(m);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        content_en = 1'b0;
        write_en   = 1'b0;
        addr0      = 4'd0;
        write_data = 32'd0;
        n_req      = 0;
        for (int l = 1; l <= 4; l++) exp_hold[l] = 32'd0;
        #1 rst_n = 1'b0;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_oob();
        test_reset_midflight();
        test_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/std_seq_mem_d1.md
# std_seq_mem_d1

Parametrised one-dimensional memory with a synchronous, pipelined read path and a per-request completion handshake. It is the next generation of the combinational-read 1-D memory primitive. It accepts one read or write request per cycle and returns read data after a configurable fixed latency. Out-of-range accesses are masked and reported. Compiled Calyx designs instantiate it as the memory cell for register-timed (non-combinational) memory ports.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1)
- SIZE, 16, number of words (≥1)
- IDX_SIZE, 4, address width; must satisfy 2^IDX_SIZE ≥ SIZE
- LATENCY, 1, cycles from request acceptance to `done`, legal range 1..4

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- addr0  input  IDX_SIZE  request address
- content_en  input  1  request valid; a request is accepted on every rising edge where this is 1
- write_en  input  1  qualifies the request: 1 = write, 0 = read; ignored when content_en=0
- write_data  input  WIDTH  write payload, sampled at acceptance
- read_data  output  WIDTH  read result; holds its value between read completions
- done  output  1  one-cycle pulse, LATENCY cycles after each accepted request
- oob  output  1  pulses together with `done` when the completing request had addr0 ≥ SIZE

## Operation
- Storage is `SIZE` words. Contents are not cleared by reset and are X until written.
- Write accept (content_en=1, write_en=1):
  - mem[addr0] ← write_data at the accepting edge, only if addr0 < SIZE.
  - The request then enters the completion pipeline.
- Read accept (content_en=1, write_en=0):
  - mem[addr0] is sampled at the accepting edge and carried down the pipeline.
  - An out-of-range read carries 0.
- Completion pipeline: LATENCY stages, each holding {valid, is_write, oob, data}.
  - Stage 0 is loaded at acceptance. Each stage shifts every cycle; there is no backpressure.
- At the final stage with valid=1:
  - done=1.
  - oob = stage oob flag.
  - read_data ← stage data, if is_write=0. On write completion read_data is unchanged.
- Requests are pipelined: back-to-back requests on consecutive cycles produce done on consecutive cycles, in order.
- Read-after-write: a read accepted one cycle after a write to the same address returns the new data. A write's commit edge precedes any later read's sample edge.
- Only one request can be accepted per cycle, so a same-cycle read and write cannot occur.

## Timing
- Reset asserted (reset=0), asynchronously:
  - all pipeline valid bits → 0
  - done=0, oob=0, read_data=0
  - no memory write occurs while reset=0, even if content_en=1
- In-flight requests are discarded by reset and never signal done.
- After reset deasserts, the first accepting edge is the next rising clk edge.
- Latency: request accepted at edge N → done, oob and read_data valid during the cycle after edge N+LATENCY−1.
  - With LATENCY=1, done is high in the cycle immediately following acceptance.
- read_data is registered. No combinational path from any input to any output.
- Throughput: 1 request per cycle.

## Structure
- Shared package `calyx_mem_pkg`:
  - `MEM_MAX_LATENCY` = 4
  - a typedef for the pipeline-stage record (valid, is_write, oob)
  - an elaboration-time check function for IDX_SIZE/SIZE/LATENCY legality
- Illegal parameters stop elaboration with `$fatal`.
- One sub-module: `std_delay_pipe` (parameters WIDTH, DEPTH). It is an async-active-low-reset shift register for valid plus payload, with the valid bits reset to 0. It is reusable by future sequential memories (d2–d4).
- The storage array and the address-range compare stay in the top module.

## Test plan
- Reset then idle, LATENCY=1:
  - hold reset=0 for 3 cycles → done=0, oob=0, read_data=0 throughout
  - release, idle 5 cycles → done remains 0
- Write/read, LATENCY=2, WIDTH=32:
  - write 0xDEADBEEF to addr 5 at edge 0 → done at edge 2, read_data stays 0
  - read addr 5 at edge 1 → done at edge 3 with read_data=0xDEADBEEF
- Back-to-back throughput, LATENCY=3:
  - write addr i = i×3 for i=0..7 on consecutive cycles, then read 0..7 on consecutive cycles
  - → 16 consecutive done pulses; read completions give 0,3,6,…,21 in order
- Out of range, SIZE=10, IDX_SIZE=4:
  - write 0x55 to addr 12 → oob=1 with done, and no word in 0..9 changes
  - read addr 12 → read_data=0, oob=1
- Reset mid-flight, LATENCY=4:
  - issue reads at addr 1 and 2
  - assert reset=0 asynchronously between edges 2 and 3 → done never pulses for either read; read_data=0 immediately
  - memory word at addr 1 retains its pre-reset value when re-read
- Parameter sweep, LATENCY ∈ {1,2,3,4}:
  - single write then read of 0xA5A5 at addr 0
  - → done exactly LATENCY cycles after each acceptance; read_data=0xA5A5
